// File: rtl/reg_file_pkg.sv
// Shared widths and types for the 8x8 register file.
// Pure declarations; no logic, no latency, no flow control.
package reg_file_pkg;

  localparam int REG_DATA_W = 8;
  localparam int REG_ADDR_W = 3;
  localparam int REG_DEPTH  = 2 ** REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One synchronous read port: enable, write-first bypass and output hold register.
// Latency 1 clk; no backpressure (output holds while rd_en is low).
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              wr_fire,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_out
);

  logic [DATA_W-1:0] rd_next;

  // A write landing on the same entry this edge wins over the stale array value.
  always_comb begin
    rd_next = rd_data;
    if (wr_fire && (wr_addr == rd_addr)) begin
      rd_next = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_out <= '0;
    end else if (rd_en) begin
      rd_out <= rd_next;
    end
  end

endmodule

// File: rtl/register_file.sv
// 8x8 register file, 2 read / 1 write ports, write-first bypass; REG0_ZERO_EN hardwires entry 0.
// Read and write-ack latency 1 clk; no backpressure, every enabled access is accepted.
module register_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] RD_addr1,
  input  logic [ADDR_W-1:0] RD_addr2,
  input  logic              RD_en1,
  input  logic              RD_en2,
  input  logic [ADDR_W-1:0] WR_addr,
  input  logic              WR_en,
  input  logic [DATA_W-1:0] WR_data,
  output logic [DATA_W-1:0] RD_out1,
  output logic [DATA_W-1:0] RD_out2,
  output logic              wr_success
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_fire;

  // wr_fire is the single notion of "accepted write": it drives storage, ack and bypass.
  always_comb begin
    wr_fire = 1'b0;
    if (WR_en) begin
      wr_fire = 1'b1;
    end
`ifdef REG0_ZERO_EN
    if (WR_addr == '0) begin
      wr_fire = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_success <= 1'b0;
    end else begin
      wr_success <= wr_fire;
      if (wr_fire) begin
        mem[WR_addr] <= WR_data;
      end
    end
  end

  reg_file_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (RD_en1),
    .rd_addr (RD_addr1),
    .rd_data (mem[RD_addr1]),
    .wr_fire (wr_fire),
    .wr_addr (WR_addr),
    .wr_data (WR_data),
    .rd_out  (RD_out1)
  );

  reg_file_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (RD_en2),
    .rd_addr (RD_addr2),
    .rd_data (mem[RD_addr2]),
    .wr_fire (wr_fire),
    .wr_addr (WR_addr),
    .wr_data (WR_data),
    .rd_out  (RD_out2)
  );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: a reference model predicts each edge's outputs.
module tb_register_file;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] RD_addr1, RD_addr2, WR_addr;
  logic       RD_en1, RD_en2, WR_en;
  logic [7:0] WR_data;
  logic [7:0] RD_out1, RD_out2;
  logic       wr_success;

  int total = 0;
  int bad   = 0;

  logic [7:0] model [8];
  logic [7:0] last1, last2;
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];
  logic       qs [$];

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       re1;
    logic [2:0] ra1;
    logic       re2;
    logic [2:0] ra2;
  } stim_t;

  register_file dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RD_addr1   (RD_addr1),
    .RD_addr2   (RD_addr2),
    .RD_en1     (RD_en1),
    .RD_en2     (RD_en2),
    .WR_addr    (WR_addr),
    .WR_en      (WR_en),
    .WR_data    (WR_data),
    .RD_out1    (RD_out1),
    .RD_out2    (RD_out2),
    .wr_success (wr_success)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    last1 = 8'h00;
    last2 = 8'h00;
    q1.delete();
    q2.delete();
    qs.delete();
  endtask

  // Drive one cycle of stimulus and push the outputs the model expects after the next edge.
  task automatic drive(input stim_t s);
    logic fire;
    WR_en    = s.we;
    WR_addr  = s.wa;
    WR_data  = s.wd;
    RD_en1   = s.re1;
    RD_addr1 = s.ra1;
    RD_en2   = s.re2;
    RD_addr2 = s.ra2;
    fire = (s.we === 1'b1);
`ifdef REG0_ZERO_EN
    if (s.wa == 3'd0) fire = 1'b0;
`endif
    if (s.re1 === 1'b1) last1 = (fire && s.wa == s.ra1) ? s.wd : model[s.ra1];
    if (s.re2 === 1'b1) last2 = (fire && s.wa == s.ra2) ? s.wd : model[s.ra2];
    q1.push_back(last1);
    q2.push_back(last2);
    qs.push_back(fire);
    if (fire) model[s.wa] = s.wd;
  endtask

  task automatic test_reset();
    logic [7:0] e1, e2;
    logic       es;
    stim_t      s;
    rst_n = 1'b0;
    s = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0};
    WR_en = 0; WR_addr = 0; WR_data = 0;
    RD_en1 = 0; RD_addr1 = 0; RD_en2 = 0; RD_addr2 = 0;
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    // Load non-zero state so a later reset has something to clear.
    s = '{1'b1, 3'd3, 8'h77, 1'b0, 3'd0, 1'b0, 3'd0};
    drive(s);
    tick();
    s = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd3};
    drive(s);
    tick();
    for (int k = 0; k < 2; k++) begin
      e1 = q1.pop_front(); e2 = q2.pop_front(); es = qs.pop_front();
      total += 3;
      if (RD_out1 !== e1 && k == 1) begin bad++; $display("FAIL preload rd_out1 got=%h want=%h", RD_out1, e1); end
      if (RD_out2 !== e2 && k == 1) begin bad++; $display("FAIL preload rd_out2 got=%h want=%h", RD_out2, e2); end
      if (k == 0) total -= 2;
      if (k == 1 && wr_success !== es) begin bad++; $display("FAIL preload wr_success got=%b want=%b", wr_success, es); end
      if (k == 0) begin
        total -= 1;
      end
    end
    #3 rst_n = 1'b0;
    #1;
    total += 3;
    if (RD_out1 !== 8'h00) begin bad++; $display("FAIL async_reset rd_out1 got=%h want=00", RD_out1); end
    if (RD_out2 !== 8'h00) begin bad++; $display("FAIL async_reset rd_out2 got=%h want=00", RD_out2); end
    if (wr_success !== 1'b0) begin bad++; $display("FAIL async_reset wr_success got=%b want=0", wr_success); end
    model_reset();
    tick();
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      s = '{1'b0, 3'd0, 8'h00, 1'b1, 3'(a), 1'b1, 3'(7 - a)};
      drive(s);
      tick();
      e1 = q1.pop_front(); e2 = q2.pop_front(); es = qs.pop_front();
      total += 3;
      if (RD_out1 !== e1) begin bad++; $display("FAIL reset_entry[%0d] rd_out1 got=%h want=%h", a, RD_out1, e1); end
      if (RD_out2 !== e2) begin bad++; $display("FAIL reset_entry[%0d] rd_out2 got=%h want=%h", 7 - a, RD_out2, e2); end
      if (wr_success !== es) begin bad++; $display("FAIL reset_entry[%0d] wr_success got=%b want=%b", a, wr_success, es); end
    end
  endtask

  task automatic run_table(input string tag, input stim_t tbl [$]);
    logic [7:0] e1, e2;
    logic       es;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      tick();
      e1 = q1.pop_front(); e2 = q2.pop_front(); es = qs.pop_front();
      total += 3;
      if (RD_out1 !== e1) begin bad++; $display("FAIL %s[%0d] rd_out1 got=%h want=%h", tag, i, RD_out1, e1); end
      if (RD_out2 !== e2) begin bad++; $display("FAIL %s[%0d] rd_out2 got=%h want=%h", tag, i, RD_out2, e2); end
      if (wr_success !== es) begin bad++; $display("FAIL %s[%0d] wr_success got=%b want=%b", tag, i, wr_success, es); end
    end
  endtask

  task automatic test_write_read();
    stim_t t [$];
    t.push_back('{1'b1, 3'd1, 8'h03, 1'b0, 3'd0, 1'b0, 3'd0});
    t.push_back('{1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b0, 3'd0});
    t.push_back('{1'b1, 3'd2, 8'h05, 1'b0, 3'd0, 1'b0, 3'd0});
    t.push_back('{1'b0, 3'd0, 8'h00, 1'b0, 3'd2, 1'b1, 3'd2});
    t.push_back('{1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b1, 3'd2});
    t.push_back('{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1, 3'd2});
    run_table("write_read", t);
  endtask

  task automatic test_bypass();
    stim_t t [$];
    t.push_back('{1'b1, 3'd4, 8'hA5, 1'b1, 3'd4, 1'b0, 3'd0});
    t.push_back('{1'b1, 3'd5, 8'h5A, 1'b1, 3'd4, 1'b1, 3'd5});
    t.push_back('{1'b1, 3'd6, 8'hC3, 1'b1, 3'd6, 1'b1, 3'd6});
    t.push_back('{1'b1, 3'd6, 8'h3C, 1'b0, 3'd6, 1'b1, 3'd5});
    t.push_back('{1'b1, 3'd0, 8'h99, 1'b1, 3'd0, 1'b1, 3'd6});
    run_table("bypass", t);
  endtask

  task automatic test_overwrite();
    stim_t t [$];
    t.push_back('{1'b1, 3'd1, 8'h05, 1'b0, 3'd0, 1'b0, 3'd0});
    t.push_back('{1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b0, 3'd0});
    t.push_back('{1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0});
    t.push_back('{1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd1});
    t.push_back('{1'b1, 3'd7, 8'hFF, 1'b1, 3'd7, 1'b1, 3'd0});
    run_table("overwrite", t);
  endtask

  // Consecutive writes keep wr_success high; random mix includes X enables.
  task automatic test_back_to_back();
    stim_t t [$];
    stim_t s;
    int    r;
    for (int i = 0; i < 4; i++) t.push_back('{1'b1, 3'(i + 2), 8'(8'h10 + i), 1'b1, 3'(i + 1), 1'b0, 3'd0});
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 5);
      s.we  = (r == 0) ? 1'bx : (r > 2);
      s.wa  = 3'($urandom_range(0, 7));
      s.wd  = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 5);
      s.re1 = (r == 1) ? 1'bx : (r > 1);
      s.ra1 = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 5);
      s.re2 = (r == 2) ? 1'bz : (r > 2);
      s.ra2 = 3'($urandom_range(0, 7));
      t.push_back(s);
    end
    run_table("back_to_back", t);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_overwrite();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
